// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks an inclusive range of architectural registers through a spare,
//   combinational register-file read port and streams (index, value) beats
//   over valid/ready. Never writes the register file.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle dump request, honoured only when idle
//   abort      synchronous cancel, wins over start
//   first_reg  first index to dump (captured with start)
//   last_reg   last index to dump, inclusive (captured with start)
//   rd_addr    register-file read address (the pointer flop)
//   rd_data    register-file read data for rd_addr, same cycle
//   out_valid  beat valid
//   out_ready  sink ready
//   out_index  register index of the current beat
//   out_data   register value of the current beat (x0 always reads 0)
//   busy       dump in progress
//   done       one-cycle pulse on normal completion (also for empty ranges)
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_index,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
      $error("regfile_dump_reader: ADDR_W must equal clog2(NUM_REGS)");
   end

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] last_q;
   logic              load;

   // The output register can take a new beat when it is empty or its
   // current beat is leaving this cycle.
   assign load    = !out_valid || out_ready;
   assign rd_addr = ptr;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         last_q    <= '0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (first_reg <= last_reg) begin
                        ptr    <= first_reg;
                        last_q <= last_reg;
                        state  <= STREAM;
                     end else begin
                        // Empty range: nothing to stream, just signal completion.
                        done <= 1'b1;
                     end
                  end
               end
               STREAM: begin
                  if (load) begin
                     // x0 is hardwired zero regardless of what the port returns.
                     out_data  <= (ptr == '0) ? '0 : rd_data;
                     out_index <= ptr;
                     out_valid <= 1'b1;
                     // Compare before increment so last_q = NUM_REGS-1 never wraps ptr.
                     if (ptr == last_q) state <= DRAIN;
                     else               ptr   <= ptr + 1'b1;
                  end
               end
               DRAIN: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//   Directed bench for regfile_dump_reader: a table of dump ranges with
//   ready patterns, plus hand sequences for reset, abort, start/abort
//   priority and asynchronous reset mid-dump.
module tb_regfile_dump_reader;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] first_reg = '0;
   logic [ADDR_W-1:0] last_reg = '0;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] out_index;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] mem [NUM_REGS];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Combinational read port model.
   assign rd_data = mem[rd_addr];

   regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_data(out_data),
      .busy(busy), .done(done)
   );

   typedef struct {
      int f;        // first_reg
      int l;        // last_reg
      int mode;     // 0: ready always 1, 1: ready pattern 1,0,0,...
      int restart;  // loop cycle at which start(0..1) is re-pulsed, -1 none
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] exp_data(input int i);
      return (i == 0) ? '0 : DATA_W'(32'h1000 + i);
   endfunction

   task automatic run_dump(input vec_t v);
      int exp_idx;
      int first_c;
      bit held;
      bit fin;
      logic [ADDR_W-1:0] h_idx;
      logic [DATA_W-1:0] h_dat;
      @(negedge clk);
      first_reg = ADDR_W'(v.f);
      last_reg  = ADDR_W'(v.l);
      start     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (v.f > v.l) begin
         chk("empty_done", done, 1);
         chk("empty_busy", busy, 0);
         chk("empty_valid", out_valid, 0);
         @(negedge clk);
         chk("empty_done_pulse", done, 0);
         chk("empty_busy2", busy, 0);
         chk("empty_valid2", out_valid, 0);
         return;
      end
      chk("capture_busy", busy, 1);
      chk("capture_valid", out_valid, 0);
      exp_idx = v.f;
      first_c = -1;
      held    = 1'b0;
      fin     = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         if (out_valid && first_c < 0) first_c = c;
         if (held) begin
            chk("stall_index_stable", out_index, h_idx);
            chk("stall_data_stable", out_data, h_dat);
         end
         if (out_valid) chk("done_mid_dump", done, 0);
         if (c == v.restart) begin
            first_reg = '0;
            last_reg  = ADDR_W'(1);
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         out_ready = (v.mode == 0) ? 1'b1 : (c % 3 == 0);
         if (out_valid && out_ready) begin
            chk("beat_index", out_index, exp_idx);
            chk("beat_data", out_data, exp_data(exp_idx));
            if (exp_idx == v.l) fin = 1'b1;
            exp_idx++;
            held = 1'b0;
         end else if (out_valid) begin
            held  = 1'b1;
            h_idx = out_index;
            h_dat = out_data;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("dump_complete", fin, 1);
      chk("first_valid_latency", first_c, 1);
      chk("done_after_last", done, 1);
      chk("busy_after_last", busy, 0);
      chk("valid_after_last", out_valid, 0);
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   vec_t vecs [7];

   initial begin
      bit found;
      vecs[0] = '{0, 31, 0, -1};   // full dump, x0 forced to zero
      vecs[1] = '{5, 8, 1, -1};    // backpressure
      vecs[2] = '{31, 31, 0, -1};  // single top register, no wrap
      vecs[3] = '{9, 3, 0, -1};    // empty range
      vecs[4] = '{10, 13, 0, 2};   // start while busy ignored
      vecs[5] = '{0, 0, 1, -1};    // single x0 beat
      vecs[6] = '{28, 31, 1, -1};  // top end under backpressure

      for (int i = 0; i < NUM_REGS; i++) mem[i] = DATA_W'(32'h1000 + i);
      mem[0] = 32'hDEAD;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_index", out_index, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_dump(vecs[i]);

      // Abort while stalled on index 12
      @(negedge clk);
      first_reg = ADDR_W'(10);
      last_reg  = ADDR_W'(20);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         out_ready = (c % 3 == 0);
         if (out_valid && out_index == ADDR_W'(12) && !out_ready) begin
            abort = 1'b1;
            found = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      chk("abort_reached_12", found, 1);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      chk("abort_done2", done, 0);
      chk("abort_idle", busy, 0);

      // Abort beats start in the same cycle
      first_reg = ADDR_W'(1);
      last_reg  = ADDR_W'(2);
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_prio_busy", busy, 0);
      chk("abort_prio_done", done, 0);

      run_dump('{2, 4, 0, -1});

      // Asynchronous reset in the middle of a stream
      @(negedge clk);
      first_reg = ADDR_W'(0);
      last_reg  = ADDR_W'(31);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_rd_addr", rd_addr, 0);
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_index", out_index, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("post_reset_valid", out_valid, 0);
      chk("post_reset_busy", busy, 0);

      run_dump('{1, 3, 1, -1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader that walks a contiguous range of architectural registers through one asynchronous register-file read port.
- Streams each (index, value) pair out over a valid/ready interface.
- Used at end of test to emit register signatures to the testbench/trace sink, and by debug logic to snapshot architectural state.
- Sits beside the register file. It owns a spare read port and never writes.

Parameters:
- NUM_REGS, 32, number of architectural registers; legal range indices 0..NUM_REGS-1.
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- first_reg  input  ADDR_W  first index to dump; captured on accepted start.
- last_reg  input  ADDR_W  last index to dump, inclusive; captured on accepted start.
- rd_addr  output  ADDR_W  register-file read address; driven directly from the pointer flop.
- rd_data  input  DATA_W  register-file read data; combinational return for rd_addr in the same cycle.
- out_valid  output  1  output beat valid.
- out_ready  input  1  sink ready.
- out_index  output  ADDR_W  register index of current beat.
- out_data  output  DATA_W  register value of current beat.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse when a dump completes normally.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, last_q=0, rd_addr=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0.
- All flops are released synchronously on the next clk edge after reset deasserts.
- States: IDLE, STREAM, DRAIN. busy = (state != IDLE). rd_addr = ptr in all states.
- IDLE, start=1, first_reg <= last_reg: ptr<=first_reg, last_q<=last_reg, go to STREAM.
- IDLE, start=1, first_reg > last_reg: empty dump. No beats are produced, done=1 on the next cycle, stay in IDLE.
- start while busy: ignored, with no effect on capture.
- STREAM: load = !out_valid || out_ready.
  - On load: out_data <= (ptr==0) ? 0 : rd_data, so x0 always reports zero. out_index<=ptr, out_valid<=1.
  - On load with ptr==last_q: go to DRAIN.
  - On load otherwise: ptr<=ptr+1.
  - No load: hold everything.
- Throughput: one beat per cycle while out_ready=1.
- Latency: first out_valid rises 2 cycles after the start edge (capture cycle, then load cycle).
- DRAIN: out_valid holds the last beat until out_ready=1. On that handshake: out_valid<=0, done<=1 for exactly one cycle, go to IDLE.
- Handshake rules:
  - A beat transfers on a cycle with out_valid & out_ready.
  - out_index and out_data are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on abort or reset.
- Sampling: a register value is sampled in its load cycle. A write to that register on the same clk edge is not seen, because the register file writes on the edge and this block samples the pre-edge read value.
  - The dump is not an atomic snapshot. The caller stalls writeback if consistency is required.
- abort=1 (any state): state<=IDLE, out_valid<=0, done stays 0. abort takes priority over start in the same cycle.
- Wrap: last_q=NUM_REGS-1 ends via the ptr==last_q compare before ptr increments, so ptr never wraps to 0.
- Single register: first_reg==last_reg gives exactly one beat.

Test Plan:
- Full dump: regfile preloaded with x[i]=0x1000+i, rd_data forced 0xDEAD for x0, first=0, last=31, out_ready=1.
  - Required: 32 consecutive beats index 0..31, data 0x0 then 0x1001..0x101F.
  - Required: first out_valid 2 cycles after start; done pulse 1 cycle after the last transfer.
- Backpressure: first=5, last=8, out_ready toggling 1,0,0,1,...
  - Required: beats 5,6,7,8 each held stable while out_ready=0, with no duplicates or drops.
  - Required: busy high until the cycle after the final handshake.
- Edge ranges: first=last=31 gives one beat index 31 then done. first=9, last=3 gives no beats, done one cycle after start, busy never high.
- Start while busy: start reasserted mid-dump with first=0, last=1.
  - Required: ignored; the original range completes unchanged.
- Abort and reset: abort asserted during backpressure at index 12.
  - Required: out_valid=0 next cycle, no done, IDLE. A new start then works normally.
  - Required: reset=0 asserted mid-STREAM clears all outputs immediately, without a clock edge.
